// File: rtl/dsound_pkg.sv
// Shared Direct Sound definitions: default FIFO geometry, DMA-compatible size
// encodings and the signed sample type handed to the mixer.
package dsound_pkg;

  localparam int DSOUND_DEPTH_BYTES = 32;
  localparam int DSOUND_REQ_THRESH  = 16;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef logic signed [7:0] sample_t;

  // Bytes carried by one access; unsupported size codes carry nothing.
  function automatic logic [2:0] push_bytes(input logic [1:0] size);
    logic [2:0] n;
    n = 3'd0;
    if (size == SZ_WORD) n = 3'd4;
    else if (size == SZ_HALF) n = 3'd2;
    return n;
  endfunction

endpackage

// File: rtl/dsound_fifo_mem.sv
// Byte storage for one Direct Sound FIFO: four write lanes landing at
// consecutive (wrapping) addresses from wr_ptr, one asynchronous read at rd_ptr.
module dsound_fifo_mem
  import dsound_pkg::*;
#(
  parameter int DEPTH_BYTES = DSOUND_DEPTH_BYTES,
  parameter int PTR_W       = $clog2(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic [3:0]       wr_lane_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [31:0]      wr_bytes,
  input  logic [PTR_W-1:0] rd_ptr,
  output sample_t          rd_data
);

  logic [7:0] mem [DEPTH_BYTES];

  // Lane i holds the i-th byte of the access; the pointer sum wraps naturally.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_lane_en[i]) mem[wr_ptr + PTR_W'(i)] <= wr_bytes[8*i +: 8];
    end
  end

  assign rd_data = sample_t'(mem[rd_ptr]);

endmodule

// File: rtl/direct_sound_fifo.sv
// Direct Sound channel FIFO: byte queue between DMA/CPU writes and the mixer,
// with a level-type DMA request. Optional stats counters: DSOUND_FIFO_STATS_EN.
module direct_sound_fifo
  import dsound_pkg::*;
#(
  parameter int DEPTH_BYTES = DSOUND_DEPTH_BYTES,
  parameter int REQ_THRESH  = DSOUND_REQ_THRESH,
  parameter int LVL_W       = $clog2(DEPTH_BYTES) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             enable,
  input  logic             fifo_reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_size,
  input  logic             wr_hi,
  input  logic [31:0]      wr_data,
  input  logic             timer_tick,
  output sample_t          sample_out,
  output logic             sample_valid,
  output logic             sound_req,
  output logic [LVL_W-1:0] level
`ifdef DSOUND_FIFO_STATS_EN
  ,
  output logic [7:0]       ovf_cnt,
  output logic [7:0]       udf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH_BYTES);

  logic [PTR_W-1:0] wptr, rptr;
  logic [2:0]       n_push;
  logic [LVL_W-1:0] n_push_l, free, level_next;
  logic             wr_drop, wr_ok, do_pop, underflow;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  sample_t          rd_data;

  // Space is judged on the pre-pop level so a write never depends on a same-cycle pop.
  always_comb begin
    n_push     = wr_en ? push_bytes(wr_size) : 3'd0;
    n_push_l   = LVL_W'(n_push);
    free       = LVL_W'(DEPTH_BYTES) - level;
    wr_drop    = (n_push != 3'd0) && (free < n_push_l);
    wr_ok      = (n_push != 3'd0) && !wr_drop;
    do_pop     = timer_tick && enable && (level != '0);
    underflow  = timer_tick && enable && (level == '0);
    level_next = level + (wr_ok ? n_push_l : '0) - (do_pop ? LVL_W'(1) : '0);
    lane_en    = '0;
    lane_data  = wr_data;
    if (wr_ok && !fifo_reset) begin
      lane_en = (n_push == 3'd4) ? 4'hF : 4'h3;
      if (n_push == 3'd2) lane_data = {16'h0000, wr_hi ? wr_data[31:16] : wr_data[15:0]};
    end
  end

  dsound_fifo_mem #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_lane_en(lane_en),
    .wr_ptr    (wptr),
    .wr_bytes  (lane_data),
    .rd_ptr    (rptr),
    .rd_data   (rd_data)
  );

  // A flush outranks any same-cycle write or tick.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      level        <= '0;
      wptr         <= '0;
      rptr         <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sound_req    <= 1'b0;
    end else if (fifo_reset) begin
      level        <= '0;
      wptr         <= '0;
      rptr         <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sound_req    <= 1'b0;
    end else begin
      level        <= level_next;
      sample_valid <= do_pop;
      sound_req    <= enable && (level_next <= LVL_W'(REQ_THRESH));
      if (wr_ok) wptr <= wptr + PTR_W'(n_push);
      if (do_pop) begin
        rptr       <= rptr + PTR_W'(1);
        sample_out <= rd_data;
      end
    end
  end

`ifdef DSOUND_FIFO_STATS_EN
  // Saturating diagnostics: dropped writes and ticks that found the FIFO empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (fifo_reset) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (wr_drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (underflow && udf_cnt != 8'hFF) udf_cnt <= udf_cnt + 8'd1;
    end
  end
`else
  logic unused_underflow;
  assign unused_underflow = underflow;
`endif

endmodule

// File: tb/tb_direct_sound_fifo.sv
// Scoreboard bench for direct_sound_fifo: a byte-queue reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_direct_sound_fifo;

  localparam logic [1:0] WORD = 2'b10;
  localparam logic [1:0] HALF = 2'b01;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        en, fifo_reset, wr_en, wr_hi, timer_tick;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic [7:0]  sample_out;
  logic        sample_valid, sound_req;
  logic [5:0]  level;
`ifdef DSOUND_FIFO_STATS_EN
  logic [7:0]  ovf_cnt, udf_cnt;
`endif

  direct_sound_fifo dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .enable      (en),
    .fifo_reset  (fifo_reset),
    .wr_en       (wr_en),
    .wr_size     (wr_size),
    .wr_hi       (wr_hi),
    .wr_data     (wr_data),
    .timer_tick  (timer_tick),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sound_req   (sound_req),
    .level       (level)
`ifdef DSOUND_FIFO_STATS_EN
    ,
    .ovf_cnt     (ovf_cnt),
    .udf_cnt     (udf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    int req;
    int smp;
    int vld;
    int ovf;
    int udf;
  } status_t;

  status_t  statusQ[$];
  int       sampleQ[$];
  int       fifoQ[$];
  int       expSample, expOvf, expUdf;
  int       nCompared, nMismatched;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte queue updated by the rules of one clock edge.
  task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic hi,
                               input logic [31:0] d, input logic tk, input logic fr);
    int n;
    bit pop;
    status_t s;
    wr_en = we; wr_size = sz; wr_hi = hi; wr_data = d; timer_tick = tk; fifo_reset = fr;
    pop = 1'b0;
    if (fr) begin
      fifoQ.delete();
      expSample = 0; expOvf = 0; expUdf = 0;
    end else begin
      n = !we ? 0 : (sz == WORD) ? 4 : (sz == HALF) ? 2 : 0;
      if (tk && en) begin
        if (fifoQ.size() > 0) begin
          pop = 1'b1;
          expSample = fifoQ.pop_front();
          sampleQ.push_back(expSample);
        end else if (expUdf < 255) expUdf++;
      end
      if (n > 0 && (32 - (fifoQ.size() + (pop ? 1 : 0))) < n) begin
        if (expOvf < 255) expOvf++;
      end else if (n == 4) begin
        for (int i = 0; i < 4; i++) fifoQ.push_back(int'(d[8*i +: 8]));
      end else if (n == 2) begin
        for (int i = 0; i < 2; i++) fifoQ.push_back(int'(d[(hi ? 16 : 0) + 8*i +: 8]));
      end
    end
    s.lvl = fifoQ.size();
    s.req = (!fr && en && fifoQ.size() <= 16) ? 1 : 0;
    s.smp = expSample;
    s.vld = pop ? 1 : 0;
    s.ovf = expOvf;
    s.udf = expUdf;
    @(posedge clk);
    statusQ.push_back(s);
    #1;
    wr_en = 1'b0; timer_tick = 1'b0; fifo_reset = 1'b0;
  endtask

  // Monitor: compares the expectation for the edge that just passed.
  always @(negedge clk) begin
    status_t s;
    int exp;
    if (statusQ.size() > 0) begin
      s = statusQ.pop_front();
      checkOutput("level", int'(level), s.lvl);
      checkOutput("sound_req", int'(sound_req), s.req);
      checkOutput("sample_valid", int'(sample_valid), s.vld);
      checkOutput("sample_out", int'(sample_out), s.smp);
`ifdef DSOUND_FIFO_STATS_EN
      checkOutput("ovf_cnt", int'(ovf_cnt), s.ovf);
      checkOutput("udf_cnt", int'(udf_cnt), s.udf);
`endif
      if (sample_valid) begin
        if (sampleQ.size() == 0) checkOutput("unexpected_sample", int'(sample_out), -1);
        else begin
          exp = sampleQ.pop_front();
          checkOutput("sample_order", int'(sample_out), exp);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic word(input logic [31:0] d, input logic tk);
    applyStimulus(1'b1, WORD, 1'b0, d, tk, 1'b0);
  endtask

  task automatic flush();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    expSample = 0; expOvf = 0; expUdf = 0;
    rst_b = 1'b0; en = 1'b1; fifo_reset = 1'b0; wr_en = 1'b0; wr_size = 2'b00;
    wr_hi = 1'b0; wr_data = 32'h0; timer_tick = 1'b0;
    #12;
    checkOutput("reset_level", int'(level), 0);
    checkOutput("reset_sample_out", int'(sample_out), 0);
    checkOutput("reset_sample_valid", int'(sample_valid), 0);
    checkOutput("reset_sound_req", int'(sound_req), 0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Fill with 0x00..0x1F, then one write too many, then drain past empty.
    for (int i = 0; i < 8; i++) word(32'h03020100 + 32'h04040404 * i, 1'b0);
    word(32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 33; i++) applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(2);

    // Halfword lane selection.
    applyStimulus(1'b1, HALF, 1'b1, 32'hBEEF0000, 1'b0, 1'b0);
    applyStimulus(1'b1, HALF, 1'b0, 32'h0000CAFE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);

    // Level 17, then push + pop together.
    flush();
    for (int i = 0; i < 4; i++) word(32'h40414243 + i, 1'b0);
    applyStimulus(1'b1, HALF, 1'b0, 32'h00005A5B, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    word(32'h11223344, 1'b1);

    // Level 30 overflow, alone and alongside a tick.
    flush();
    for (int i = 0; i < 7; i++) word(32'h70717273 + i, 1'b0);
    applyStimulus(1'b1, HALF, 1'b1, 32'h99880000, 1'b0, 1'b0);
    word(32'hCCCCCCCC, 1'b0);
    word(32'hDDDDDDDD, 1'b1);

    // Flush at level 12 with a write and tick in the same cycle.
    flush();
    for (int i = 0; i < 3; i++) word(32'hA0A1A2A3 + i, 1'b0);
    applyStimulus(1'b1, WORD, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1);
    idle(2);

    // Disabled channel ignores ticks and withholds the request.
    word(32'h01020304, 1'b0);
    en = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    en = 1'b1;
    idle(1);

`ifdef DSOUND_FIFO_STATS_EN
    // Drive both counters into saturation, then clear them.
    flush();
    for (int i = 0; i < 260; i++) applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) word(32'h55555555, 1'b0);
    for (int i = 0; i < 260; i++) word(32'h66666666, 1'b0);
    flush();
    idle(1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] sz;
      en = ($urandom_range(0, 15) != 0);
      sz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? WORD : HALF);
      applyStimulus(1'($urandom_range(0, 2) == 0), sz, 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    end
    idle(1);

    @(negedge clk); #1;
    checkOutput("leftover_samples", sampleQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
